fifo_in_arb: RTL and testbench

Sequencer and arbiter for the input-FIFO bus slave (sel/wr/address/din/dout, fifo_cnt, fifo_flag) in the factorial machine.

- Two requesters share the slave:
  - the host side, which pushes 32-bit operands;
  - the factorial engine, which pops them.
- The block grants one bus access at a time, round-robin, gated by the FIFO full/empty flags.
- It generates the slave's bus cycles and returns read data to the engine with a valid pulse.
- It keeps 16-bit push/pop/error statistics.

---
 rtl/fifo_in_arb_pkg.sv | 31 +++
 rtl/fifo_in_arb_rr_arb2.sv | 41 ++++
 rtl/fifo_in_arb.sv | 167 ++++++++++++++++
 tb/tb_fifo_in_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_in_arb_pkg.sv
// Shared definitions for the input-FIFO sequencer/arbiter: FSM states,
// slave flag bit positions, default slave addresses and small helpers.
package fifo_in_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_RDWAIT = 2'd3
  } state_e;

  localparam int unsigned FLAG_FULL   = 0;
  localparam int unsigned FLAG_EMPTY  = 1;
  localparam int unsigned FLAG_AFULL  = 2;
  localparam int unsigned FLAG_AEMPTY = 3;
  localparam int unsigned FLAG_WERR   = 4;
  localparam int unsigned FLAG_RERR   = 5;

  // Requester positions inside the arbiter request/grant vectors
  localparam int unsigned IDX_HOST = 0;
  localparam int unsigned IDX_ENG  = 1;

  localparam logic [7:0] DEF_WR_ADDR = 8'h11;
  localparam logic [7:0] DEF_RD_ADDR = 8'h10;

  // True when the slave reports either a write or a read error
  function automatic logic any_err(input logic [5:0] flag);
    return flag[FLAG_WERR] | flag[FLAG_RERR];
  endfunction

endpackage

// File: rtl/fifo_in_arb_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester not served last wins;
// the history bit only moves when the caller accepts a grant.
module rr_arb2
  import fifo_in_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = engine was granted last, so the host wins the first tie after reset
  logic       last_gnt_q;
  logic [1:0] gnt_s;

  // One-hot grant from the current requests and the last-granted history
  always_comb begin
    gnt_s = 2'b00;
    case (req_i)
      2'b01:   gnt_s = 2'b01;
      2'b10:   gnt_s = 2'b10;
      2'b11:   gnt_s = last_gnt_q ? 2'b01 : 2'b10;
      default: gnt_s = 2'b00;
    endcase
  end

  assign gnt_o = gnt_s;

  // Remember which side won, only when the grant is actually taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
    end else if (accept_i && (gnt_s != 2'b00)) begin
      last_gnt_q <= gnt_s[IDX_ENG];
    end else begin
      last_gnt_q <= last_gnt_q;
    end
  end

endmodule

// File: rtl/fifo_in_arb.sv
// Sequencer/arbiter for the input-FIFO bus slave: the host pushes operands,
// the factorial engine pops them. One access at a time, always returning to
// IDLE so the slave flags settle before the next grant decision.
module fifo_in_arb
  import fifo_in_arb_pkg::*;
#(
  parameter logic [7:0]  WR_ADDR = DEF_WR_ADDR,
  parameter logic [7:0]  RD_ADDR = DEF_RD_ADDR,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             h_req,
  input  logic [31:0]      h_data,
  output logic             h_ack,
  input  logic             e_req,
  output logic             e_valid,
  output logic [31:0]      e_data,
  output logic             sel,
  output logic             wr,
  output logic [7:0]       address,
  output logic [31:0]      din,
  input  logic [31:0]      dout,
  input  logic [3:0]       fifo_cnt,
  input  logic [5:0]       fifo_flag,
  output logic [CNT_W-1:0] push_cnt,
  output logic [CNT_W-1:0] pop_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q;
  logic             sel_q;
  logic             wr_q;
  logic [7:0]       address_q;
  logic [31:0]      din_q;
  logic             h_ack_q;
  logic             e_valid_q;
  logic [31:0]      e_data_q;
  logic             busy_q;
  logic [CNT_W-1:0] push_cnt_q;
  logic [CNT_W-1:0] pop_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [1:0]       req_s;
  logic [1:0]       gnt_s;
  logic             accept_s;
  logic             unused_s;

  // Occupancy and the almost-full/empty hints are informational only
  assign unused_s = ^{fifo_cnt, fifo_flag[FLAG_AFULL], fifo_flag[FLAG_AEMPTY]};

  // Eligibility: host blocked by full, engine blocked by empty
  assign req_s[IDX_HOST] = h_req & ~fifo_flag[FLAG_FULL];
  assign req_s[IDX_ENG]  = e_req & ~fifo_flag[FLAG_EMPTY];
  assign accept_s        = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req_s),
    .accept_i (accept_s),
    .gnt_o    (gnt_s)
  );

  // Access FSM with registered bus, handshake and busy outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      address_q <= 8'h00;
      din_q     <= 32'h0000_0000;
      h_ack_q   <= 1'b0;
      e_valid_q <= 1'b0;
      e_data_q  <= 32'h0000_0000;
      busy_q    <= 1'b0;
    end else begin
      // Bus idles and pulses clear unless the next state drives them
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      address_q <= 8'h00;
      din_q     <= 32'h0000_0000;
      h_ack_q   <= 1'b0;
      e_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_s[IDX_HOST]) begin
            state_q   <= ST_WRITE;
            sel_q     <= 1'b1;
            wr_q      <= 1'b1;
            address_q <= WR_ADDR;
            din_q     <= h_data;
            h_ack_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else if (gnt_s[IDX_ENG]) begin
            state_q   <= ST_READ;
            sel_q     <= 1'b1;
            address_q <= RD_ADDR;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
        end
        ST_READ: begin
          state_q <= ST_RDWAIT;
          busy_q  <= 1'b1;
        end
        ST_RDWAIT: begin
          // Slave read data is valid during this cycle
          state_q   <= ST_IDLE;
          e_data_q  <= dout;
          e_valid_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics: pushes/pops wrap, error cycles saturate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_cnt_q <= CNT_ZERO;
      pop_cnt_q  <= CNT_ZERO;
      err_cnt_q  <= CNT_ZERO;
    end else begin
      if (state_q == ST_WRITE) begin
        push_cnt_q <= push_cnt_q + CNT_ONE;
      end else begin
        push_cnt_q <= push_cnt_q;
      end
      if (state_q == ST_RDWAIT) begin
        pop_cnt_q <= pop_cnt_q + CNT_ONE;
      end else begin
        pop_cnt_q <= pop_cnt_q;
      end
      if (any_err(fifo_flag) && (err_cnt_q != CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + CNT_ONE;
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  assign sel      = sel_q;
  assign wr       = wr_q;
  assign address  = address_q;
  assign din      = din_q;
  assign h_ack    = h_ack_q;
  assign e_valid  = e_valid_q;
  assign e_data   = e_data_q;
  assign busy     = busy_q;
  assign push_cnt = push_cnt_q;
  assign pop_cnt  = pop_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fifo_in_arb.sv
// Bench for fifo_in_arb: a queue-based FIFO slave, request drivers for host
// and engine, a transaction-level reference model that predicts every
// ack/valid (cycle and data), and a monitor that checks them as they appear.
module tb_fifo_in_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        h_req, e_req, h_ack, e_valid, sel, wr, busy;
  logic [31:0] h_data, e_data, din, dout;
  logic [7:0]  address;
  logic [3:0]  fifo_cnt;
  logic [5:0]  fifo_flag;
  logic [15:0] push_cnt, pop_cnt, err_cnt;

  fifo_in_arb dut (
    .clk(clk), .reset_n(reset_n), .h_req(h_req), .h_data(h_data), .h_ack(h_ack),
    .e_req(e_req), .e_valid(e_valid), .e_data(e_data), .sel(sel), .wr(wr),
    .address(address), .din(din), .dout(dout), .fifo_cnt(fifo_cnt),
    .fifo_flag(fifo_flag), .push_cnt(push_cnt), .pop_cnt(pop_cnt),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO slave (depth 8) ----------------
  logic [31:0] sq[$];
  int          s_cnt   = 0;
  logic [31:0] s_dout  = 32'h0;
  logic        inj_werr = 1'b0;
  logic        inj_rerr = 1'b0;

  always @(posedge clk) begin
    if (sel && wr) begin
      if (sq.size() < 8) sq.push_back(din);
    end else if (sel && !wr) begin
      if (sq.size() > 0) s_dout <= sq.pop_front();
    end
    s_cnt <= sq.size();
  end

  assign dout      = s_dout;
  assign fifo_cnt  = 4'(s_cnt);
  assign fifo_flag = {inj_rerr, inj_werr, (s_cnt <= 1), (s_cnt >= 7), (s_cnt == 0), (s_cnt == 8)};

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] cyc; logic [31:0] data; } exp_t;
  exp_t        exp_ack[$];
  exp_t        exp_val[$];
  logic [31:0] mfifo[$];
  int          m_hold = 0;
  bit          m_last_eng = 1'b1;
  int unsigned m_push = 0, m_pop = 0, m_err = 0;

  always @(posedge clk) begin : model
    bit   he, ee, ph, pe;
    exp_t e;
    if (!reset_n) begin
      exp_ack.delete(); exp_val.delete();
      m_hold = 0; m_last_eng = 1'b1; m_push = 0; m_pop = 0; m_err = 0;
    end else begin
      if ((fifo_flag[4] || fifo_flag[5]) && m_err < 65535) m_err++;
      if (m_hold > 0) begin
        m_hold--;
      end else begin
        he = h_req && !fifo_flag[0];
        ee = e_req && !fifo_flag[1];
        ph = he && (!ee || m_last_eng);
        pe = ee && !ph;
        if (ph) begin
          e.cyc = cyc + 1; e.data = h_data;
          exp_ack.push_back(e); mfifo.push_back(h_data);
          m_push++; m_last_eng = 1'b0; m_hold = 1;
        end else if (pe) begin
          e.cyc = cyc + 3;
          if (mfifo.size() > 0) e.data = mfifo.pop_front();
          else e.data = 32'hDEAD_BEEF;
          exp_val.push_back(e);
          m_pop++; m_last_eng = 1'b1; m_hold = 2;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  glog[$];
  int          acks_seen = 0, vals_seen = 0;
  logic [31:0] last_edata = 32'h0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      last_edata = 32'h0;
    end else begin
      chk("busy", 32'(busy), 32'(m_hold != 0));
      chk("err_cnt", 32'(err_cnt), m_err & 32'h0000_FFFF);
      chk("ack_vs_write", 32'(h_ack), 32'(sel && wr));
      if (!sel) chk("idle_bus", 32'(wr) | 32'(address) | din, 32'h0);
      if (h_ack) begin
        acks_seen++; glog.push_back(8'h48);
        chk("ack_expected", 32'(exp_ack.size() > 0), 32'd1);
        if (exp_ack.size() > 0) begin
          e = exp_ack.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("wr_data", din, e.data);
          chk("wr_addr", 32'(address), 32'h11);
        end
      end else if (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
        chk("missing_ack", cyc, exp_ack[0].cyc);
        void'(exp_ack.pop_front());
      end
      if (sel && !wr) begin
        glog.push_back(8'h45);
        chk("rd_addr", 32'(address), 32'h10);
      end
      if (e_valid) begin
        vals_seen++;
        chk("valid_expected", 32'(exp_val.size() > 0), 32'd1);
        if (exp_val.size() > 0) begin
          e = exp_val.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("e_data", e_data, e.data);
          last_edata = e.data;
        end
      end else if (exp_val.size() > 0 && exp_val[0].cyc < cyc) begin
        chk("missing_valid", cyc, exp_val[0].cyc);
        void'(exp_val.pop_front());
      end
      chk("e_data_hold", e_data, last_edata);
    end
  end

  // ---------------- request drivers ----------------
  logic [31:0] hq[$];
  int          e_todo = 0;
  bit          host_abort = 1'b0, eng_abort = 1'b0, rnd_gap = 1'b0;

  initial begin
    h_req = 1'b0; h_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || host_abort) begin
        h_req = 1'b0; hq.delete();
      end else begin
        if (h_req && h_ack) h_req = 1'b0;
        if (!h_req && hq.size() > 0 && (!rnd_gap || $urandom_range(2, 0) != 0)) begin
          h_data = hq.pop_front(); h_req = 1'b1;
        end
      end
    end
  end

  initial begin
    e_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || eng_abort) begin
        e_req = 1'b0; e_todo = 0;
      end else begin
        if (e_req && e_valid) e_req = 1'b0;
        if (!e_req && e_todo > 0 && (!rnd_gap || $urandom_range(2, 0) != 0)) begin
          e_todo--; e_req = 1'b1;
        end
      end
    end
  end

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while (!(hq.size() == 0 && !h_req && e_todo == 0 && !e_req && m_hold == 0 &&
             exp_ack.size() == 0 && exp_val.size() == 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({name, "_done_in_time"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c, np, npop, lo, v0, a0;
    bit found;
    logic [15:0] e0;
    logic [31:0] v;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel_wr_addr", {22'h0, sel, wr, address}, 32'h0);
    chk("rst_din", din, 32'h0);
    chk("rst_pulses", {30'h0, h_ack, e_valid}, 32'h0);
    chk("rst_e_data", e_data, 32'h0);
    chk("rst_counts", {push_cnt, pop_cnt}, 32'h0);
    chk("rst_err_busy", {15'h0, err_cnt, busy}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Host-only fill of an empty FIFO, then a 9th push must stall
    for (int i = 1; i <= 8; i++) hq.push_back(32'h1111_1111 * i);
    wait_quiet("fill", 200);
    chk("fill_acks", 32'(acks_seen), 32'd8);
    chk("push_cnt_8", 32'(push_cnt), 32'd8);
    hq.push_back(32'h9999_9999);
    repeat (12) @(negedge clk);
    chk("full_blocks_push", 32'(acks_seen), 32'd8);
    host_abort = 1'b1; repeat (2) @(negedge clk); host_abort = 1'b0;

    // Engine drains the full FIFO in order, then a further pop must stall
    e_todo = 8;
    wait_quiet("drain", 200);
    chk("drain_valids", 32'(vals_seen), 32'd8);
    chk("pop_cnt_8", 32'(pop_cnt), 32'd8);
    e_todo = 1;
    repeat (12) @(negedge clk);
    chk("empty_blocks_pop", 32'(vals_seen), 32'd8);
    eng_abort = 1'b1; repeat (2) @(negedge clk); eng_abort = 1'b0;

    // Fresh reset, FIFO preloaded to 4, both requesters held: H,E,H,E...
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    sq.delete(); mfifo.delete();
    for (int i = 0; i < 4; i++) begin
      v = $urandom; sq.push_back(v); mfifo.push_back(v);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst2_counts", {push_cnt, pop_cnt}, 32'h0);
    @(negedge clk);
    glog.delete();
    for (int i = 0; i < 4; i++) hq.push_back($urandom);
    e_todo = 4;
    wait_quiet("tie", 200);
    chk("tie_len", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk("tie_order", 32'(glog[i]), (i % 2 == 0) ? 32'h48 : 32'h45);

    // Read-error flag held three cycles while traffic continues
    e0 = err_cnt; a0 = acks_seen;
    hq.push_back($urandom); hq.push_back($urandom);
    @(posedge clk); #1 inj_rerr = 1'b1;
    repeat (3) @(posedge clk);
    #1 inj_rerr = 1'b0;
    wait_quiet("errinj", 200);
    chk("err_delta", 32'(16'(err_cnt - e0)), 32'd3);
    chk("err_acks", 32'(acks_seen - a0), 32'd2);

    // Randomised mixed traffic with random request gaps
    rnd_gap = 1'b1;
    repeat (4) begin
      c    = sq.size();
      np   = $urandom_range(10, 3);
      lo   = (np > 8 - c) ? np - (8 - c) : 0;
      npop = $urandom_range(c + np, lo);
      for (int i = 0; i < np; i++) hq.push_back($urandom);
      e_todo = npop;
      wait_quiet("random", 800);
      chk("rand_push_cnt", 32'(push_cnt), m_push & 32'h0000_FFFF);
      chk("rand_pop_cnt", 32'(pop_cnt), m_pop & 32'h0000_FFFF);
    end
    rnd_gap = 1'b0;

    // Reset asserted during a READ cycle aborts the pop
    if (sq.size() == 0) begin
      hq.push_back(32'hCAFE_F00D);
      wait_quiet("prefill", 100);
    end
    e_todo = 1; found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(posedge clk); #1;
      if (sel && !wr) found = 1'b1;
    end
    chk("read_seen", 32'(found), 32'd1);
    if (found) begin
      v0 = vals_seen;
      reset_n = 1'b0;
      #1;
      chk("abort_sel_wr_addr", {22'h0, sel, wr, address}, 32'h0);
      chk("abort_din_edata", din | e_data, 32'h0);
      chk("abort_pulses_busy", {29'h0, h_ack, e_valid, busy}, 32'h0);
      eng_abort = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("no_valid_in_reset", 32'(e_valid), 32'd0);
      end
      reset_n = 1'b1;
      eng_abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_abort_busy", 32'(busy), 32'd0);
      chk("post_abort_counts", {push_cnt, pop_cnt}, 32'h0);
      chk("post_abort_err", 32'(err_cnt), 32'd0);
      chk("post_abort_no_valid", 32'(vals_seen - v0), 32'd0);
    end

    chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    chk("valid_queue_empty", 32'(exp_val.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
